keypad_scan_ctrl: RTL and testbench

//  Sequencing controller for the 4x4 matrix keypad: drives row strobes at a programmable dwell rate
//  and synchronises and debounces the column returns. Detects debounced press/release of a single key
//  and queues key events in a small FIFO. Events reach the host through a valid/ready interface.

---
 rtl/kp_pkg.sv | 70 +++++++
 rtl/kp_event_fifo.sv | 51 +++++
 rtl/keypad_scan_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kp_pkg.sv
// Shared types, key codes and the row/column decode for the 4x4 keypad scanner.
package kp_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE_P,
    HELD,
    DEBOUNCE_R
  } kp_state_t;

  localparam logic [3:0] KEY_0 = 4'h0;
  localparam logic [3:0] KEY_1 = 4'h1;
  localparam logic [3:0] KEY_2 = 4'h2;
  localparam logic [3:0] KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4;
  localparam logic [3:0] KEY_5 = 4'h5;
  localparam logic [3:0] KEY_6 = 4'h6;
  localparam logic [3:0] KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8;
  localparam logic [3:0] KEY_9 = 4'h9;
  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_D = 4'hD;
  localparam logic [3:0] KEY_E = 4'hE;
  localparam logic [3:0] KEY_F = 4'hF;
  localparam logic [3:0] KEY_STAR = KEY_E;
  localparam logic [3:0] KEY_HASH = KEY_F;

  localparam logic EVT_PRESS   = 1'b1;
  localparam logic EVT_RELEASE = 1'b0;

  // Returns {valid, code}; valid only when exactly one column is pulled low.
  function automatic logic [4:0] kp_decode(input logic [1:0] row_idx, input logic [3:0] col);
    logic       v;
    logic [1:0] c;
    logic [3:0] code;
    v    = 1'b1;
    c    = 2'd0;
    code = KEY_0;
    case (col)
      4'b1110: c = 2'd0;
      4'b1101: c = 2'd1;
      4'b1011: c = 2'd2;
      4'b0111: c = 2'd3;
      default: v = 1'b0;
    endcase
    case ({row_idx, c})
      4'h0: code = KEY_1;
      4'h1: code = KEY_2;
      4'h2: code = KEY_3;
      4'h3: code = KEY_A;
      4'h4: code = KEY_4;
      4'h5: code = KEY_5;
      4'h6: code = KEY_6;
      4'h7: code = KEY_B;
      4'h8: code = KEY_7;
      4'h9: code = KEY_8;
      4'hA: code = KEY_9;
      4'hB: code = KEY_C;
      4'hC: code = KEY_STAR;
      4'hD: code = KEY_0;
      4'hE: code = KEY_HASH;
      4'hF: code = KEY_D;
      default: code = KEY_0;
    endcase
    return {v, code};
  endfunction

endpackage

// File: rtl/kp_event_fifo.sv
// First-word-fall-through event FIFO; when empty the head output holds the last popped word.
module kp_event_fifo #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] last;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    head    = empty ? last : mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      last   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last   <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad row scanner with column debounce and a press/release event FIFO.
// Optional auto-repeat of held keys is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_scan_ctrl
  import kp_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES    = 64,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned FIFO_DEPTH      = 4
`ifdef KEYPAD_AUTOREPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = 500000,
  parameter int unsigned REPEAT_RATE     = 100000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_en,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [4:0] evt_data,
  output logic       overflow,
  input  logic       ovf_clr,
  output logic       key_down
);

  localparam int unsigned DW  = $clog2(DWELL_CYCLES + 1);
  localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0]  DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [DBW-1:0] DEB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);

  kp_state_t      state;
  logic [1:0]     idx;
  logic [1:0]     idx_nxt;
  logic [DW-1:0]  dwell_cnt;
  logic [DBW-1:0] deb_cnt;
  logic [3:0]     col_m;
  logic [3:0]     col_s;
  logic [3:0]     lat_col;
  logic [3:0]     lat_code;
  logic [4:0]     dec;
  logic           push_en;
  logic [4:0]     push_data;
  logic           fifo_full;
  logic           fifo_empty;
  logic           pop;

  function automatic logic [3:0] row_mask(input logic [1:0] i);
    return ~(4'b0001 << i);
  endfunction

  always_comb begin
    idx_nxt   = idx + 2'd1;
    dec       = kp_decode(idx, col_s);
    evt_valid = !fifo_empty;
    pop       = evt_valid && evt_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_m <= '1;
      col_s <= '1;
    end else begin
      col_m <= col;
      col_s <= col_m;
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RW      = $clog2(REP_MAX + 1);

  logic [RW-1:0] rep_cnt;
  logic          rep_first;
  logic          rep_fire;

  always_comb begin
    rep_fire = (state == HELD) && (col_s == lat_col) &&
               (rep_cnt == (rep_first ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_RATE - 1)));
  end

  // Any excursion out of HELD (including a bounce into DEBOUNCE_R) restarts the initial delay.
  always_ff @(posedge clk) begin
    if (reset || !scan_en || state != HELD) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (rep_fire) begin
      rep_cnt   <= '0;
      rep_first <= 1'b0;
    end else if (rep_cnt != '1) begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SCAN;
      idx       <= '0;
      row       <= '1;
      dwell_cnt <= '0;
      deb_cnt   <= '0;
      lat_col   <= '1;
      lat_code  <= '0;
      key_down  <= 1'b0;
      push_en   <= 1'b0;
      push_data <= '0;
    end else begin
      push_en <= 1'b0;
      if (!scan_en) begin
        state     <= SCAN;
        idx       <= '0;
        row       <= '1;
        dwell_cnt <= '0;
        deb_cnt   <= '0;
        key_down  <= 1'b0;
      end else begin
        case (state)
          SCAN: begin
            // Dwell only counts once the strobe for idx is actually on the pins.
            if (row != row_mask(idx)) begin
              row       <= row_mask(idx);
              dwell_cnt <= '0;
            end else if (dwell_cnt == DWELL_LAST) begin
              if (dec[4]) begin
                lat_col  <= col_s;
                lat_code <= dec[3:0];
                deb_cnt  <= '0;
                state    <= DEBOUNCE_P;
              end else begin
                idx       <= idx_nxt;
                row       <= row_mask(idx_nxt);
                dwell_cnt <= '0;
              end
            end else begin
              dwell_cnt <= dwell_cnt + 1'b1;
            end
          end
          DEBOUNCE_P: begin
            if (col_s != lat_col) begin
              state     <= SCAN;
              idx       <= idx_nxt;
              row       <= row_mask(idx_nxt);
              dwell_cnt <= '0;
              deb_cnt   <= '0;
            end else if (deb_cnt == DEB_LAST) begin
              push_en   <= 1'b1;
              push_data <= {EVT_PRESS, lat_code};
              key_down  <= 1'b1;
              deb_cnt   <= '0;
              state     <= HELD;
            end else begin
              deb_cnt <= deb_cnt + 1'b1;
            end
          end
          HELD: begin
            if (col_s != lat_col) begin
              deb_cnt <= '0;
              state   <= DEBOUNCE_R;
            end
`ifdef KEYPAD_AUTOREPEAT_EN
            else if (rep_fire) begin
              push_en   <= 1'b1;
              push_data <= {EVT_PRESS, lat_code};
            end
`endif
          end
          DEBOUNCE_R: begin
            if (col_s == lat_col) begin
              deb_cnt <= '0;
              state   <= HELD;
            end else if (deb_cnt == DEB_LAST) begin
              push_en   <= 1'b1;
              push_data <= {EVT_RELEASE, lat_code};
              key_down  <= 1'b0;
              state     <= SCAN;
              idx       <= idx_nxt;
              row       <= row_mask(idx_nxt);
              dwell_cnt <= '0;
              deb_cnt   <= '0;
            end else begin
              deb_cnt <= deb_cnt + 1'b1;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (push_en && fifo_full && !pop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  kp_event_fifo #(
    .WIDTH (5),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_en),
    .push_data (push_data),
    .pop       (pop),
    .head      (evt_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: keypad matrix model, event scoreboard and directed/random key sequences.
module tb_keypad_scan_ctrl;

  localparam int unsigned DWELL = 4;
  localparam int unsigned DEB   = 8;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scan_en = 1'b0;
  logic       evt_ready = 1'b1;
  logic       ovf_clr = 1'b0;
  logic [3:0] col;
  logic [3:0] row;
  logic       evt_valid;
  logic [4:0] evt_data;
  logic       overflow;
  logic       key_down;

  int checks = 0;
  int failures = 0;

  logic [4:0] exp_q [$];
  logic       exp_ovf = 1'b0;
  logic       key_on = 1'b0;
  logic       ghost_on = 1'b0;
  logic [1:0] key_r = 2'd0;
  logic [1:0] key_c = 2'd0;

  // Physical key legend, row by row, left to right.
  logic [3:0] keymap [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                                '{4'h4, 4'h5, 4'h6, 4'hB},
                                '{4'h7, 4'h8, 4'h9, 4'hC},
                                '{4'hE, 4'h0, 4'hF, 4'hD}};

  keypad_scan_ctrl #(
    .DWELL_CYCLES    (DWELL),
    .DEBOUNCE_CYCLES (DEB),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .scan_en   (scan_en),
    .col       (col),
    .row       (row),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_data  (evt_data),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr),
    .key_down  (key_down)
  );

  always #5 clk = ~clk;

  // Switch matrix: a closed key shorts its column to its row when that row is strobed low.
  always_comb begin
    col = 4'hF;
    if (ghost_on && row[0] == 1'b0) col = 4'b1100;
    else if (key_on && row[key_r] == 1'b0) col[key_c] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Host-visible FIFO model: with the host stalled, only DEPTH events fit.
  task automatic model_push(input logic [4:0] ev);
    if (!evt_ready && exp_q.size() >= DEPTH) exp_ovf = 1'b1;
    else exp_q.push_back(ev);
  endtask

  task automatic wait_kd(input logic v, input int max, input string tag);
    int n;
    n = 0;
    while (key_down !== v && n < max) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(key_down), 32'(v));
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic press_release(input logic [1:0] r, input logic [1:0] c, input int hold);
    key_r = r;
    key_c = c;
    model_push({1'b1, keymap[r][c]});
    key_on = 1'b1;
    wait_kd(1'b1, 80, "press_key_down");
    repeat (hold) tick();
    @(negedge clk);
    check("held_key_down", 32'(key_down), 32'd1);
    tick();
    key_on = 1'b0;
    model_push({1'b0, keymap[r][c]});
    wait_kd(1'b0, 80, "release_key_down");
    repeat (6) tick();
  endtask

  // Scoreboard: every accepted event must match the model order; stalled head must not move.
  logic       prev_stall = 1'b0;
  logic [4:0] prev_data = '0;
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(evt_valid), 32'd1);
        check("stall_data", 32'(evt_data), 32'(prev_data));
      end
      if (evt_valid && evt_ready) begin
        check("evt_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("evt_data", 32'(evt_data), 32'(exp_q.pop_front()));
      end
      prev_stall = evt_valid && !evt_ready;
      prev_data  = evt_data;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] er;
    logic [4:0] held;
    int         n;
    int         toggles;

    // Reset values, then free scan through all four rows and the wrap.
    scan_en = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_row", 32'(row), 32'hF);
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_data", 32'(evt_data), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_key_down", 32'(key_down), 32'd0);
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      er = ~(4'b0001 << ((k / DWELL) % 4));
      check("scan_row", 32'(row), 32'(er));
    end
    check("scan_no_evt", 32'(evt_valid), 32'd0);

    // Key '5' held, then released.
    press_release(2'd1, 2'd1, 40);
    drain("drain_key5");

    // Key '9' bouncing before settling.
    tick();
    key_r = 2'd2;
    key_c = 2'd2;
    model_push({1'b1, keymap[2][2]});
    toggles = 2 * $urandom_range(3, 6);
    for (int i = 0; i < toggles; i++) begin
      key_on = ~key_on;
      repeat (3) tick();
    end
    key_on = 1'b1;
    n = 0;
    while (!key_down && n < 80) begin
      @(negedge clk);
      n++;
    end
    check("bounce_key_down", 32'(key_down), 32'd1);
    check("bounce_min_latency", 32'(n >= DEB), 32'd1);
    repeat (10) tick();
    key_on = 1'b0;
    model_push({1'b0, keymap[2][2]});
    wait_kd(1'b0, 80, "bounce_release");
    drain("drain_key9");

    // Ghost on row 0: ignored, scan advances to row 1.
    ghost_on = 1'b1;
    n = 0;
    while (row !== 4'b1110 && n < 24) begin
      @(negedge clk);
      n++;
    end
    check("ghost_row0", 32'(row), 32'hE);
    n = 0;
    while (row !== 4'b1101 && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("ghost_row1", 32'(row), 32'hD);
    repeat (40) tick();
    @(negedge clk);
    check("ghost_key_down", 32'(key_down), 32'd0);
    check("ghost_no_evt", 32'(evt_valid), 32'd0);
    ghost_on = 1'b0;

    // Random keys with varying hold times.
    for (int i = 0; i < 6; i++) begin
      press_release(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom_range(2, 30));
      drain("drain_random");
    end

    // Host stalled across five press/release pairs.
    tick();
    evt_ready = 1'b0;
    exp_ovf = 1'b0;
    for (int i = 0; i < 5; i++)
      press_release(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom_range(2, 10));
    @(negedge clk);
    check("ovf_set", 32'(overflow), 32'(exp_ovf));
    check("ovf_kept", 32'(exp_q.size()), 32'(DEPTH));
    check("ovf_valid", 32'(evt_valid), 32'd1);
    check("ovf_head", 32'(evt_data), 32'(exp_q[0]));
    held = evt_data;
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    @(negedge clk);
    check("ovf_clr", 32'(overflow), 32'd0);
    repeat (5) tick();
    @(negedge clk);
    check("stall_head_hold", 32'(evt_data), 32'(held));
    tick();
    evt_ready = 1'b1;
    drain("drain_ovf");

    // '#' held, then scanning disabled: no release event, queued press survives.
    tick();
    evt_ready = 1'b0;
    key_r = 2'd3;
    key_c = 2'd2;
    model_push({1'b1, keymap[3][2]});
    key_on = 1'b1;
    wait_kd(1'b1, 80, "hash_key_down");
    tick();
    scan_en = 1'b0;
    tick();
    @(negedge clk);
    check("dis_row", 32'(row), 32'hF);
    check("dis_key_down", 32'(key_down), 32'd0);
    check("dis_valid", 32'(evt_valid), 32'd1);
    check("dis_head", 32'(evt_data), 32'(exp_q[0]));
    repeat (20) tick();
    @(negedge clk);
    check("dis_row_idle", 32'(row), 32'hF);
    check("dis_queued", 32'(evt_data), 32'(exp_q[0]));
    tick();
    evt_ready = 1'b1;
    drain("drain_hash");
    repeat (5) tick();
    @(negedge clk);
    check("dis_empty", 32'(evt_valid), 32'd0);
    check("dis_last_data", 32'(evt_data), 32'h1F);
    tick();
    key_on = 1'b0;
    scan_en = 1'b1;

    // Reset mid-operation discards queued events.
    evt_ready = 1'b0;
    key_r = 2'd0;
    key_c = 2'd3;
    model_push({1'b1, keymap[0][3]});
    key_on = 1'b1;
    wait_kd(1'b1, 80, "mid_key_down");
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    check("mid_rst_row", 32'(row), 32'hF);
    check("mid_rst_key_down", 32'(key_down), 32'd0);
    check("mid_rst_valid", 32'(evt_valid), 32'd0);
    check("mid_rst_data", 32'(evt_data), 32'd0);
    exp_q.delete();
    key_on = 1'b0;
    evt_ready = 1'b1;
    tick();
    reset = 1'b0;
    repeat (10) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
